// File: rtl/color_history_scanner.sv
// Color-history scanner: clears the per-pixel history RAM, streams history beats to the
// corner detector and applies its write-back. Define HIST_FWD_EN to forward same-cycle write-back data.
module color_history_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int HIST_W   = 4,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              VGA_VS,
  input  logic              pix_valid,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_color,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [HIST_W-1:0] updated_color_history,
  output logic              out_valid,
  output logic              median_color,
  output logic [HIST_W-1:0] color_history,
  output logic [ADDR_W-1:0] read_addr,
  output logic [9:0]        read_x,
  output logic [9:0]        read_y,
  output logic              busy,
  output logic [7:0]        frame_count
);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W:0]   TOTAL_A = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {CLEAR, WAIT_VS, ACTIVE} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              color;
  } pix_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [7:0]        frame_q, frame_d;
  logic              vs_q, vs_prev_q, vs_fall;
  logic [1:0]        vld_pipe_q;
  pix_t              s1_q, s2_q;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic              mem_we, wb_ok, in_range, accept, hazard;
  logic [ADDR_W-1:0] mem_waddr, addr_calc;
  logic [HIST_W-1:0] mem_wdata;
  logic [HIST_W-1:0] mem [TOTAL];

  assign vs_fall   = vs_prev_q & ~vs_q;
  assign in_range  = ({22'd0, pix_x} < 32'(H_ACTIVE)) && ({22'd0, pix_y} < 32'(V_ACTIVE));
  assign accept    = pix_valid && in_range && (state_q == ACTIVE);
  assign wb_ok     = we && (state_q != CLEAR) && ({1'b0, write_addr} < TOTAL_A);
  assign addr_calc = ADDR_W'(pix_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(pix_x);
  assign hazard    = wb_ok && (write_addr == s1_q.addr);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    frame_d   = frame_q;
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = updated_color_history;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_A) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        mem_we = wb_ok;
        if (vs_fall) state_d = ACTIVE;
      end
      ACTIVE: begin
        mem_we = wb_ok;
        if (vs_fall) frame_d = frame_q + 8'd1;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Write and stage-1 read collide only when write-back targets the address being read.
`ifdef HIST_FWD_EN
  assign hist_d = hazard ? updated_color_history : mem[s1_q.addr];
`else
  assign hist_d = mem[s1_q.addr];
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      frame_q    <= '0;
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      hist_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      frame_q    <= frame_d;
      vs_q       <= VGA_VS;
      vs_prev_q  <= vs_q;
      vld_pipe_q <= {vld_pipe_q[0], accept};
      if (accept)
        s1_q <= '{addr: addr_calc, x: pix_x, y: pix_y, color: pix_color};
      if (vld_pipe_q[0]) begin
        s2_q   <= s1_q;
        hist_q <= hist_d;
      end
    end
  end

  assign out_valid     = vld_pipe_q[1];
  assign median_color  = s2_q.color;
  assign read_addr     = s2_q.addr;
  assign read_x        = s2_q.x;
  assign read_y        = s2_q.y;
  assign color_history = hist_q;
  assign busy          = (state_q == CLEAR);
  assign frame_count   = frame_q;
endmodule

// File: tb/tb_color_history_scanner.sv
// Scoreboard bench for color_history_scanner on a small frame; the reference keeps an array
// image of the history RAM and derives each beat's expected history from write order.
module tb_color_history_scanner;
  localparam int H = 32, V = 15, HW = 4, AW = 9, TOTAL = H * V;

  logic          clk, reset, VGA_VS, pix_valid, pix_color, we;
  logic [9:0]    pix_x, pix_y;
  logic [AW-1:0] write_addr;
  logic [HW-1:0] updated_color_history;
  logic          out_valid, median_color, busy;
  logic [HW-1:0] color_history;
  logic [AW-1:0] read_addr;
  logic [9:0]    read_x, read_y;
  logic [7:0]    frame_count;

  color_history_scanner #(.H_ACTIVE(H), .V_ACTIVE(V), .HIST_W(HW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_color(pix_color), .we(we), .write_addr(write_addr),
    .updated_color_history(updated_color_history), .out_valid(out_valid),
    .median_color(median_color), .color_history(color_history), .read_addr(read_addr),
    .read_x(read_x), .read_y(read_y), .busy(busy), .frame_count(frame_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr; int x; int y; bit c; logic [HW-1:0] h;
  } exp_t;

  exp_t          q[$];
  logic [HW-1:0] model_mem [TOTAL];
  bit            mode_active, mode_wb, pend;
  exp_t          pend_e;
  int            fc_exp, errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        checks++;
        if (read_addr !== AW'(e.addr) || read_x !== 10'(e.x) || read_y !== 10'(e.y) ||
            median_color !== e.c || color_history !== e.h) begin
          errors++;
          $display("FAIL beat: got addr=%0d x=%0d y=%0d c=%0b h=%0h expected addr=%0d x=%0d y=%0d c=%0b h=%0h",
                   read_addr, read_x, read_y, median_color, color_history,
                   e.addr, e.x, e.y, e.c, e.h);
        end
      end
    end
  end

  // One clock cycle of stimulus; the model runs at the sampling edge.
  task automatic step(input bit pv, input int x, input int y, input bit c,
                      input bit w, input int wa, input logic [HW-1:0] wd);
    exp_t e;
    pix_valid = pv; pix_x = 10'(x); pix_y = 10'(y); pix_color = c;
    we = w; write_addr = AW'(wa); updated_color_history = wd;
    @(posedge clk);
    if (pend) begin
      e = pend_e;
      e.h = model_mem[e.addr];
`ifdef HIST_FWD_EN
      if (w && mode_wb && wa < TOTAL && wa == e.addr) e.h = wd;
`endif
      q.push_back(e);
      pend = 0;
    end
    if (w && mode_wb && wa < TOTAL) model_mem[wa] = wd;
    if (pv && mode_active && x < H && y < V) begin
      pend = 1;
      pend_e.addr = y * H + x; pend_e.x = x; pend_e.y = y; pend_e.c = c; pend_e.h = '0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_color_history"}, color_history, 0);
    chk({tag, "_read_addr"}, read_addr, 0);
    chk({tag, "_read_xy_color"}, {read_x, read_y, median_color}, 0);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2 * TOTAL) begin
      n++;
      step($urandom_range(0, 1), $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'b1,
           $urandom_range(0, 1), $urandom_range(0, TOTAL - 1), 4'hF);
    end
    chk({tag, "_clear_cycles"}, n, TOTAL);
    chk({tag, "_busy_after_clear"}, busy, 0);
  endtask

  task automatic enter_active();
    mode_wb = 1;
    VGA_VS = 1'b0;
    idle(4);
    mode_active = 1;
    VGA_VS = 1'b1;
  endtask

  initial begin
    int x, y, wa, pa;
    bit pv, vs_n;
    errors = 0; checks = 0; fc_exp = 0; pend = 0; pa = 0;
    mode_active = 0; mode_wb = 0;
    foreach (model_mem[i]) model_mem[i] = '0;
    reset = 1'b1; VGA_VS = 1'b1;
    pix_valid = 0; pix_x = '0; pix_y = '0; pix_color = 0;
    we = 0; write_addr = '0; updated_color_history = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    wait_clear("first");

    // WAIT_VS: beats ignored, write-back honoured
    mode_wb = 1;
    for (int i = 0; i < 10; i++)
      step(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'b1,
           1'b1, $urandom_range(0, TOTAL - 1), 4'($urandom));
    enter_active();
    chk("frame_count_after_wait_vs", frame_count, 0);

    // basic read, write-back then read, hazard, range drops
    step(1, 3, 2, 1, 0, 0, '0); idle(3);
    step(0, 0, 0, 0, 1, 2 * H + 3, 4'b1010); idle(4);
    step(1, 3, 2, 0, 0, 0, '0); idle(3);
    step(1, 3, 2, 1, 0, 0, '0);
    step(0, 0, 0, 0, 1, 2 * H + 3, 4'b0111); idle(3);
    step(1, 3, 2, 1, 0, 0, '0); idle(3);
    step(1, H, 0, 1, 0, 0, '0);
    step(1, 0, V, 1, 0, 0, '0);
    step(1, 1023, 1023, 1, 0, 0, '0); idle(3);

    // random traffic with hazards, out-of-range writes and VS edges
    for (int i = 0; i < 3000; i++) begin
      pv = ($urandom_range(0, 3) != 0);
      x  = $urandom_range(0, H + 2);
      y  = $urandom_range(0, V + 1);
      wa = ($urandom_range(0, 3) == 0) ? pa : $urandom_range(0, (1 << AW) - 1);
      vs_n = ($urandom_range(0, 7) == 0) ? ~VGA_VS : VGA_VS;
      if (VGA_VS && !vs_n) fc_exp++;
      VGA_VS = vs_n;
      step(pv, x, y, 1'($urandom), 1'($urandom), wa, 4'($urandom));
      pa = (y * H + x) % (1 << AW);
    end
    idle(6);
    chk("frame_count_random", frame_count, fc_exp % 256);

    for (int i = 0; i < 257; i++) begin
      VGA_VS = 1'b1; idle(2);
      VGA_VS = 1'b0; idle(2);
      fc_exp++;
    end
    idle(4);
    chk("frame_count_257", frame_count, fc_exp % 256);

    // reset abort: dirty the RAM ends, keep beats in flight, then reset mid-cycle
    step(0, 0, 0, 0, 1, 0, 4'hF);
    step(0, 0, 0, 0, 1, TOTAL - 1, 4'h9);
    step(1, 5, 5, 1, 0, 0, '0);
    step(1, 6, 5, 1, 0, 0, '0);
    #2;
    reset = 1'b1;
    VGA_VS = 1'b1;
    q.delete(); pend = 0; mode_active = 0; mode_wb = 0; fc_exp = 0;
    foreach (model_mem[i]) model_mem[i] = '0;
    #1;
    check_reset_vals("abort");
    pix_valid = 0; we = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clear("second");
    enter_active();
    step(1, 0, 0, 1, 0, 0, '0);
    step(1, H - 1, V - 1, 1, 0, 0, '0);
    idle(4);

    chk("scoreboard_drained", q.size() + 32'(pend), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/color_history_scanner.md
Name: color_history_scanner

Overview:
- Feeds the per-pixel color-history stream to the green-corner detector and absorbs its write-back, closing the read/modify/write loop on the history RAM.
- Owns the H_ACTIVE x V_ACTIVE history RAM, which is HIST_W bits per pixel.
- Converts incoming median-filtered pixels (x, y, color bit) into read_addr/read_x/read_y/color_history/median_color beats.
- Applies the detector's updated_color_history writes, and clears the RAM after reset.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- HIST_W, 4, history bits per pixel.
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- VGA_VS  in  1  vertical sync; a falling edge marks a new frame.
- pix_valid  in  1  pixel beat valid.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- pix_color  in  1  median-filtered green bit.
- we  in  1  write-back enable from the detector.
- write_addr  in  ADDR_W  write-back address.
- updated_color_history  in  HIST_W  write-back data.
- out_valid  out  1  output beat valid.
- median_color  out  1  delayed pix_color.
- color_history  out  HIST_W  stored history for the pixel.
- read_addr  out  ADDR_W  pixel address.
- read_x  out  10  pixel column.
- read_y  out  10  pixel row.
- busy  out  1  high while clearing the RAM.
- frame_count  out  8  VS falling-edge counter.

Interface decision: one clock (clk); reset is asynchronous and active-high.

Behaviour:
- Reset values: out_valid=0, median_color=0, color_history=0, read_addr=0, read_x=0, read_y=0, frame_count=0, busy=1, state=CLEAR, clear pointer=0. Reset asserted mid-operation aborts everything and restarts CLEAR at address 0.
- State machine:
  - CLEAR: one zero write per cycle at the clear pointer. Leaves after writing address H_ACTIVE*V_ACTIVE-1 (307199 with defaults), i.e. 307200 cycles after reset release. busy=1 throughout. pix_valid and we are ignored.
  - CLEAR -> WAIT_VS: busy drops the cycle after the last clear write.
  - WAIT_VS -> ACTIVE: on the first VS falling edge (VS registered; edge = prev & ~cur). Pixels are ignored in WAIT_VS.
  - ACTIVE: stays in ACTIVE until reset. Every VS falling edge increments frame_count modulo 256 (255 -> 0).
- Pixel pipeline, ACTIVE only, pixel beat accepted in cycle N:
  - Stage 1, edge N+1: registers x, y, color, and addr = y*H_ACTIVE + x computed in ADDR_W bits (shift-add for 640: (y<<9)+(y<<7)+x), then issues the RAM read.
  - Stage 2, edge N+2: registers the RAM read data and presents it with out_valid=1. Latency is 2 cycles. Throughput is 1 pixel per cycle with no backpressure.
  - out_valid=0 in every cycle with no corresponding accepted beat.
- Range check: a beat with pix_x >= H_ACTIVE or pix_y >= V_ACTIVE is dropped. There is no read and no out_valid.
- Write-back:
  - In ACTIVE, and also in WAIT_VS, we=1 writes updated_color_history to write_addr at that edge.
  - write_addr >= H_ACTIVE*V_ACTIVE is ignored.
- RAM: simple dual-port, synchronous read, old-data read-during-write.
- Simultaneous read/write hazard: the write-back and the stage-1 read hit the same address in the same cycle (see Optional Feature).
- Simultaneous VS edge and pixel beat: both are handled; the pixel is not dropped.

Optional Feature:
- Macro: HIST_FWD_EN.
- Defined: in the hazard case, stage 2 outputs updated_color_history (the write data) instead of the stale RAM word.
- Undefined: stage 2 outputs the old RAM word; the hazard is a known one-frame history slip.

Test Plan:
- Clear after reset: release reset -> busy=1 for exactly 307200 cycles, then 0. A sampled read of address 0 and of address 307199 returns 4'b0000.
- Basic read: in ACTIVE, pix_valid with x=3, y=2, color=1 -> two cycles later out_valid=1, read_addr=1283, read_x=3, read_y=2, median_color=1, color_history=0.
- Write-back then read: we with write_addr=1283, data=4'b1010, then pixel (3,2) five cycles later -> color_history=4'b1010.
- Forwarding hazard: write 4'b0111 to addr 1283 in the same cycle as the stage-1 read of (3,2) -> output 4'b0111 with HIST_FWD_EN defined; the prior value without it.
- Range drop and ignored beats:
  - pix_x=640, y=0 -> no out_valid.
  - pix_y=480 -> no out_valid.
  - Beats during CLEAR or WAIT_VS -> no out_valid.
- Frame counter and reset abort: 257 VS falling edges in ACTIVE -> frame_count=1. Asserting reset mid-ACTIVE -> all outputs return to reset values immediately and busy=1.
